// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, command encoding and digit decrement helper
package bcd_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic [1:0] {CMD_HOLD, CMD_LOAD, CMD_SHIFT, CMD_COUNT} cmd_e;
    function automatic logic [BCD_W:0] bcd_dec(input logic [BCD_W-1:0] digit, input logic borrow_in);
        return (digit > BCD_MAX) ? {1'b0, 4'd0} :
               !borrow_in        ? {1'b0, digit} :
               (digit == 4'd0)   ? {1'b1, BCD_MAX} :
                                   {1'b0, digit - 4'd1};
    endfunction
endpackage

// File: rtl/jk_ff_rn.sv
// jk_ff_rn: JK flip-flop with synchronous active-low clear
module jk_ff_rn (
    input  logic clk,
    input  logic rst_n,
    input  logic J,
    input  logic K,
    output logic q
);
    // clear wins; otherwise hold/reset/set/toggle per J,K
    always_ff @(posedge clk)
        q <= !rst_n ? 1'b0 : (J & K) ? ~q : J ? 1'b1 : K ? 1'b0 : q;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD down-counter built from JK flops with load/shift/count
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  count,
    input  logic                  shift,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   in,
    output logic [4*DIGITS-1:0]   out,
    output logic                  zero,
    output logic                  borrow_out
);
    localparam int W = BCD_W * DIGITS;
    cmd_e cmd;
    logic [W-1:0] out_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] out_d;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic active;
    // command priority: count > shift > load > hold
    always_comb
        cmd = count ? CMD_COUNT : shift ? CMD_SHIFT : load ? CMD_LOAD : CMD_HOLD;
    // ripple the borrow from the least significant digit upward
    always_comb begin
        logic b;
        logic [BCD_W:0] r;
        b = 1'b1;
        r = '0;
        cnt_d = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r = bcd_dec(out_q[d*BCD_W +: BCD_W], b);
            cnt_d[d*BCD_W +: BCD_W] = r[BCD_W-1:0];
            b = r[BCD_W];
        end
    end
    // next value and JK drive; hold leaves J=K=0 so toggle never occurs
    always_comb begin
        out_d = (cmd == CMD_COUNT) ? cnt_d :
                (cmd == CMD_SHIFT) ? {out_q[0], out_q[W-1:1]} :
                (cmd == CMD_LOAD)  ? in : out_q;
        active = cmd != CMD_HOLD;
        j = {W{active}} & out_d;
        k = {W{active}} & ~out_d;
    end
    for (genvar i = 0; i < W; i++) begin : g_ff
        jk_ff_rn u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .J     (j[i]),
            .K     (k[i]),
            .q     (out_q[i])
        );
    end
    assign out = out_q;
    assign zero = out_q == '0;
    assign borrow_out = count & zero;
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed scoreboard bench for the 2-digit BCD down-counter
module tb_bcd_down_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic count = 1'b0;
    logic shift = 1'b0;
    logic load = 1'b0;
    logic [7:0] in = 8'h00;
    logic [7:0] out;
    logic zero;
    logic borrow_out;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count      (count),
        .shift      (shift),
        .load       (load),
        .in         (in),
        .out        (out),
        .zero       (zero),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rn, input logic c, input logic s, input logic l,
                        input logic [7:0] v, input logic [7:0] exp_out, input logic exp_b,
                        input string tag);
        logic [7:0] e;
        @(negedge clk);
        rst_n = rn; count = c; shift = s; load = l; in = v;
        exp_q.push_back(exp_out);
        #1;
        checks++;
        assert (borrow_out === exp_b) else begin
            errors++;
            $error("FAIL %s borrow_out got %b want %b", tag, borrow_out, exp_b);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (out === e) else begin
            errors++;
            $error("FAIL %s out got %h want %h", tag, out, e);
        end
        checks++;
        assert (zero === (e == 8'h00)) else begin
            errors++;
            $error("FAIL %s zero got %b want %b", tag, zero, e == 8'h00);
        end
    endtask

    initial begin
        step(0, 0, 0, 1, 8'h57, 8'h00, 0, "rst1");
        step(0, 0, 0, 1, 8'h57, 8'h00, 0, "rst2");
        step(1, 0, 0, 1, 8'h57, 8'h57, 0, "rel_load");
        step(1, 0, 0, 1, 8'h21, 8'h21, 0, "load21");
        step(1, 1, 0, 0, 8'h00, 8'h20, 0, "cnt20");
        step(1, 1, 0, 0, 8'h00, 8'h19, 0, "cnt19");
        step(1, 1, 0, 0, 8'h00, 8'h18, 0, "cnt18");
        step(1, 0, 0, 1, 8'h01, 8'h01, 0, "load01");
        step(1, 1, 0, 0, 8'h00, 8'h00, 0, "cnt00");
        step(1, 1, 0, 0, 8'h00, 8'h99, 1, "wrap99");
        step(1, 0, 0, 0, 8'h00, 8'h99, 0, "hold99");
        step(1, 0, 0, 1, 8'h10, 8'h10, 0, "load10");
        step(1, 1, 1, 1, 8'h55, 8'h09, 0, "prio_cnt");
        step(1, 0, 1, 1, 8'h55, 8'h84, 0, "prio_shift");
        step(1, 0, 1, 0, 8'h00, 8'h42, 0, "shift42");
        step(1, 0, 0, 1, 8'h3C, 8'h3C, 0, "load3c");
        step(1, 1, 0, 0, 8'h00, 8'h30, 0, "inval30");
        step(1, 1, 0, 0, 8'h00, 8'h29, 0, "cnt29");
        step(1, 0, 0, 1, 8'hFF, 8'hFF, 0, "loadff");
        step(1, 1, 0, 0, 8'h00, 8'h00, 0, "invalff");
        step(1, 0, 0, 1, 8'h45, 8'h45, 0, "load45");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h00, 8'h45, 0, "hold45");
        step(1, 1, 0, 0, 8'h00, 8'h44, 0, "cnt44");
        step(0, 1, 0, 0, 8'h00, 8'h00, 0, "rst_mid");
        step(0, 1, 0, 0, 8'h00, 8'h00, 1, "rst_borrow");
        step(1, 1, 0, 0, 8'h00, 8'h99, 1, "resume99");
        step(1, 0, 0, 0, 8'h00, 8'h99, 0, "hold_end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
